// File: rtl/osc_cal_pkg.sv
// osc_cal_pkg: shared types, widths and code decode helper for the oscillator calibration loop
package osc_cal_pkg;
    localparam int CODE_W = 9;
    localparam int LSB_W  = 5;
    localparam int MSB_W  = 8;

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, UPDATE} cal_state_t;

    function automatic logic [MSB_W-1:0] code_to_therm(input logic [CODE_W-1:0] code);
        logic [MSB_W-1:0] t;
        for (int i = 0; i < MSB_W; i++) t[i] = code[CODE_W-1:LSB_W] > i[CODE_W-LSB_W-1:0];
        return t;
    endfunction
endpackage

// File: rtl/osc_freq_cal_if.sv
// osc_freq_cal_if: calibration control/status bundle between the loop and its host/oscillator
interface osc_freq_cal_if
    import osc_cal_pkg::*;
#(
    parameter int CNT_W = 16
) ();
    logic             cal_en;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] osc_cnt;
    logic [LSB_W-1:0] delay_con_lsb;
    logic [MSB_W-1:0] delay_con_msb;
    logic [CODE_W-1:0] code;
    logic             locked;
    logic             busy;
    logic             sat;

    modport master (
        output cal_en, target, osc_cnt,
        input  delay_con_lsb, delay_con_msb, code, locked, busy, sat
    );

    modport slave (
        input  cal_en, target, osc_cnt,
        output delay_con_lsb, delay_con_msb, code, locked, busy, sat
    );
endinterface

// File: rtl/osc_cal_code_dec.sv
// osc_cal_code_dec: splits a delay code into binary LSB and thermometer MSB varactor controls
module osc_cal_code_dec
    import osc_cal_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [LSB_W-1:0]  lsb,
    output logic [MSB_W-1:0]  msb
);
    assign lsb = code[LSB_W-1:0];
    assign msb = code_to_therm(code);
endmodule

// File: rtl/osc_freq_cal.sv
// osc_freq_cal: window-based frequency measurement stepping the ring-oscillator delay code toward target
module osc_freq_cal
    import osc_cal_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int WIN_LOG2    = 8,
    parameter int SETTLE_CYC  = 4,
    parameter int TOL         = 2,
    parameter int COARSE_TH   = 32,
    parameter int COARSE_STEP = 8,
    parameter int LOCK_CNT    = 3,
    parameter int CODE_INIT   = 144,
    parameter int CODE_MAX    = 287
) (
    input logic           ref_clk,
    input logic           rst,
    osc_freq_cal_if.slave bus
);
    localparam int CW   = WIN_LOG2 + 1;
    localparam int LC_W = $clog2(LOCK_CNT + 1);
    localparam int NW   = CODE_W + 2;

    localparam logic [CW-1:0]          WIN_LAST = CW'((1 << WIN_LOG2) - 1);
    localparam logic [CW-1:0]          SET_LAST = CW'(SETTLE_CYC - 1);
    localparam logic signed [CNT_W:0]  TOL_S    = (CNT_W + 1)'(TOL);
    localparam logic [CNT_W:0]         TH_U     = (CNT_W + 1)'(COARSE_TH);
    localparam logic signed [NW-1:0]   CSTEP_S  = NW'(COARSE_STEP);
    localparam logic signed [NW-1:0]   FSTEP_S  = NW'(1);
    localparam logic signed [NW-1:0]   MAX_S    = NW'(CODE_MAX);
    localparam logic [CODE_W-1:0]      CODE_MX  = CODE_W'(CODE_MAX);
    localparam logic [CODE_W-1:0]      CODE_IN  = CODE_W'(CODE_INIT);
    localparam logic [LC_W-1:0]        LC_MAX   = LC_W'(LOCK_CNT);

    cal_state_t          state;
    logic [CW-1:0]       cnt;
    logic [CNT_W-1:0]    start;
    logic [CNT_W-1:0]    delta;
    logic [CODE_W-1:0]   code_q;
    logic [LC_W-1:0]     lock_cnt;
    logic                locked_q;
    logic                sat_q;
    logic                busy_q;

    logic signed [CNT_W:0] err;
    logic [CNT_W:0]        mag;
    logic                  up, dn, in_tol;
    logic signed [NW-1:0]  step, nxt;
    logic                  hi, lo;
    logic [CODE_W-1:0]     code_n;

    assign err    = $signed({1'b0, delta}) - $signed({1'b0, bus.target});
    assign mag    = err[CNT_W] ? $unsigned(-err) : $unsigned(err);
    assign up     = err > TOL_S;
    assign dn     = err < -TOL_S;
    assign in_tol = !up && !dn;
    assign step   = mag > TH_U ? CSTEP_S : FSTEP_S;
    assign nxt    = $signed({2'b00, code_q}) + (up ? step : dn ? -step : '0);
    assign hi     = nxt > MAX_S;
    assign lo     = nxt[NW-1];
    assign code_n = hi ? CODE_MX : lo ? '0 : nxt[CODE_W-1:0];

    // Sequencer: settle, measure one window, then apply one clamped code step
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            start    <= '0;
            delta    <= '0;
            code_q   <= CODE_IN;
            lock_cnt <= '0;
            locked_q <= 1'b0;
            sat_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else if (!bus.cal_en) begin
            state    <= IDLE;
            cnt      <= '0;
            lock_cnt <= '0;
            locked_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state  <= SETTLE;
                    start  <= bus.osc_cnt;
                    cnt    <= '0;
                    busy_q <= 1'b1;
                end
                SETTLE: begin
                    state <= cnt == SET_LAST ? MEASURE : SETTLE;
                    cnt   <= cnt == SET_LAST ? '0 : cnt + 1'b1;
                end
                MEASURE: begin
                    state <= cnt == WIN_LAST ? UPDATE : MEASURE;
                    cnt   <= cnt == WIN_LAST ? '0 : cnt + 1'b1;
                    if (cnt == WIN_LAST) delta <= bus.osc_cnt - start;
                end
                UPDATE: begin
                    state    <= SETTLE;
                    start    <= bus.osc_cnt;
                    code_q   <= code_n;
                    sat_q    <= hi || lo;
                    lock_cnt <= !in_tol ? '0 : lock_cnt == LC_MAX ? LC_MAX : lock_cnt + 1'b1;
                    locked_q <= in_tol && lock_cnt >= LC_MAX - 1'b1;
                end
            endcase
        end
    end

    assign bus.code   = code_q;
    assign bus.locked = locked_q;
    assign bus.sat    = sat_q;
    assign bus.busy   = busy_q;

    osc_cal_code_dec u_dec (
        .code (code_q),
        .lsb  (bus.delay_con_lsb),
        .msb  (bus.delay_con_msb)
    );
endmodule

// File: tb/tb_osc_freq_cal.sv
// tb_osc_freq_cal: randomized scenario checks of the calibration loop against a window-level model
module tb_osc_freq_cal;
    logic ref_clk = 1'b0;
    logic rst = 1'b1;

    osc_freq_cal_if #(.CNT_W(16)) bus ();

    osc_freq_cal dut (
        .ref_clk (ref_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 ref_clk = ~ref_clk;

    int     n_chk = 0;
    int     n_fail = 0;
    longint acc = 0;
    int     rate = 0;
    int     tgt = 1000;
    int     m_code = 144;
    int     m_lock = 0;
    bit     m_sat = 0;

    // Oscillator model: count advances by exactly rate per 260 ref_clk cycles (settle + window)
    task automatic tick();
        @(negedge ref_clk);
        acc += longint'(rate);
        bus.osc_cnt = 16'(acc / 260);
    endtask

    function automatic void model_update(input int d);
        int err, st, nc;
        err = d - tgt;
        st = (err > 32 || err < -32) ? 8 : 1;
        nc = err > 2 ? m_code + st : err < -2 ? m_code - st : m_code;
        m_sat = nc > 287 || nc < 0;
        m_code = nc > 287 ? 287 : nc < 0 ? 0 : nc;
        m_lock = (err >= -2 && err <= 2) ? (m_lock == 3 ? 3 : m_lock + 1) : 0;
    endfunction

    task automatic enable();
        tick();
        bus.cal_en = 1'b1;
    endtask

    task automatic disable_cal();
        bus.cal_en = 1'b0;
        tick();
        tick();
        m_lock = 0;
    endtask

    task automatic run_window(input int d);
        rate = d;
        repeat (261) tick();
        @(posedge ref_clk);
        #1;
        model_update(d);
    endtask

    task automatic test_reset();
        bus.cal_en = 1'b0;
        bus.target = 16'd1000;
        bus.osc_cnt = 16'd0;
        tick();
        tick();
        n_chk++; if (bus.code !== 9'd144) begin n_fail++; $display("FAIL reset_code: got %0d want 144", bus.code); end
        n_chk++; if (bus.delay_con_lsb !== 5'd16) begin n_fail++; $display("FAIL reset_lsb: got %0d want 16", bus.delay_con_lsb); end
        n_chk++; if (bus.delay_con_msb !== 8'h0F) begin n_fail++; $display("FAIL reset_msb: got %h want 0f", bus.delay_con_msb); end
        n_chk++; if ({bus.locked, bus.busy, bus.sat} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {bus.locked, bus.busy, bus.sat}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_coarse();
        tgt = 1000;
        bus.target = 16'd1000;
        acc = longint'($urandom);
        rate = 1100;
        enable();
        repeat (261) tick();
        n_chk++; if (bus.code !== 9'd144 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL coarse_early: got code %0d busy %b want 144 1", bus.code, bus.busy); end
        @(posedge ref_clk);
        #1;
        model_update(1100);
        n_chk++; if (bus.code !== 9'(m_code) || m_code != 152) begin n_fail++; $display("FAIL coarse_code: got %0d want 152", bus.code); end
        n_chk++; if (bus.delay_con_lsb !== 5'(m_code % 32) || bus.delay_con_msb !== 8'((1 << (m_code / 32)) - 1)) begin n_fail++; $display("FAIL coarse_dec: got %0d/%h for code %0d", bus.delay_con_lsb, bus.delay_con_msb, m_code); end
        n_chk++; if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL coarse_sat: got %b want 0", bus.sat); end
    endtask

    task automatic test_async_reset();
        repeat (100) tick();
        #2 rst = 1'b1;
        bus.cal_en = 1'b0;
        #1;
        n_chk++; if (bus.code !== 9'd144 || bus.delay_con_lsb !== 5'd16 || bus.delay_con_msb !== 8'h0F) begin n_fail++; $display("FAIL async_rst_code: got %0d/%0d/%h want 144/16/0f", bus.code, bus.delay_con_lsb, bus.delay_con_msb); end
        n_chk++; if (bus.locked !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_flags: got locked %b busy %b want 0 0", bus.locked, bus.busy); end
        tick();
        rst = 1'b0;
        m_code = 144;
        m_sat = 0;
        m_lock = 0;
        tick();
    endtask

    task automatic test_lock();
        tgt = 1000;
        bus.target = 16'd1000;
        enable();
        for (int w = 0; w < 3; w++) begin
            run_window(1001);
            n_chk++; if (bus.code !== 9'(m_code)) begin n_fail++; $display("FAIL lock_code w%0d: got %0d want %0d", w, bus.code, m_code); end
            n_chk++; if (bus.locked !== (m_lock == 3)) begin n_fail++; $display("FAIL lock_flag w%0d: got %b want %b", w, bus.locked, m_lock == 3); end
        end
        run_window(1004);
        n_chk++; if (bus.code !== 9'(m_code) || bus.locked !== 1'b0) begin n_fail++; $display("FAIL lock_loss: got code %0d locked %b want %0d 0", bus.code, bus.locked, m_code); end
        disable_cal();
    endtask

    task automatic test_saturation();
        int d;
        tgt = int'($urandom_range(500, 5000));
        bus.target = 16'(tgt);
        enable();
        while (m_code != 285) begin
            d = (285 - m_code >= 8) ? tgt + 100 : tgt + 5;
            run_window(d);
            n_chk++; if (bus.code !== 9'(m_code) || bus.sat !== m_sat) begin n_fail++; $display("FAIL sat_climb: got %0d/%b want %0d/%b", bus.code, bus.sat, m_code, m_sat); end
        end
        for (int r = 0; r < 2; r++) begin
            run_window(tgt + 100);
            n_chk++; if (bus.code !== 9'd287 || bus.sat !== 1'b1) begin n_fail++; $display("FAIL sat_hi r%0d: got %0d/%b want 287/1", r, bus.code, bus.sat); end
            n_chk++; if (bus.delay_con_msb !== 8'hFF || bus.delay_con_lsb !== 5'd31) begin n_fail++; $display("FAIL sat_hi_dec r%0d: got %h/%0d want ff/31", r, bus.delay_con_msb, bus.delay_con_lsb); end
        end
        run_window(tgt + 1);
        n_chk++; if (bus.code !== 9'd287 || bus.sat !== 1'b0) begin n_fail++; $display("FAIL sat_clear: got %0d/%b want 287/0", bus.code, bus.sat); end
        while (m_code != 0) begin
            run_window(tgt - 100);
            n_chk++; if (bus.code !== 9'(m_code) || bus.sat !== m_sat) begin n_fail++; $display("FAIL sat_fall: got %0d/%b want %0d/%b", bus.code, bus.sat, m_code, m_sat); end
        end
        run_window(tgt - 5);
        n_chk++; if (bus.code !== 9'd0 || bus.sat !== 1'b1 || bus.delay_con_msb !== 8'h00) begin n_fail++; $display("FAIL sat_lo: got %0d/%b/%h want 0/1/00", bus.code, bus.sat, bus.delay_con_msb); end
        disable_cal();
    endtask

    task automatic test_wrap();
        int c0;
        tgt = 1000;
        bus.target = 16'd1000;
        c0 = m_code;
        rate = 0;
        acc = 64'd260 * 64'hFF80;
        enable();
        run_window(1000);
        n_chk++; if (bus.code !== 9'(c0) || m_code != c0 || bus.sat !== 1'b0) begin n_fail++; $display("FAIL wrap: got %0d/%b want %0d/0", bus.code, bus.sat, c0); end
        disable_cal();
    endtask

    task automatic test_cal_en_drop();
        tgt = 1000;
        bus.target = 16'd1000;
        enable();
        repeat (3) run_window(1000);
        n_chk++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL drop_prelock: got %b want 1", bus.locked); end
        rate = 1300;
        repeat (120) tick();
        bus.cal_en = 1'b0;
        m_lock = 0;
        tick();
        n_chk++; if (bus.busy !== 1'b0 || bus.locked !== 1'b0 || bus.code !== 9'(m_code)) begin n_fail++; $display("FAIL drop_idle: got busy %b locked %b code %0d want 0 0 %0d", bus.busy, bus.locked, bus.code, m_code); end
        repeat (5) tick();
        enable();
        rate = 1100;
        repeat (261) tick();
        n_chk++; if (bus.code !== 9'(m_code) || bus.busy !== 1'b1) begin n_fail++; $display("FAIL reenable_early: got %0d busy %b want %0d 1", bus.code, bus.busy, m_code); end
        @(posedge ref_clk);
        #1;
        model_update(1100);
        n_chk++; if (bus.code !== 9'(m_code)) begin n_fail++; $display("FAIL reenable_code: got %0d want %0d", bus.code, m_code); end
        disable_cal();
    endtask

    task automatic test_random();
        int d;
        for (int r = 0; r < 3; r++) begin
            tgt = int'($urandom_range(200, 20000));
            bus.target = 16'(tgt);
            acc = longint'($urandom);
            enable();
            for (int w = 0; w < 10; w++) begin
                d = ($urandom_range(0, 2) == 0) ? tgt + int'($urandom_range(0, 6)) - 3 : tgt + int'($urandom_range(0, 140)) - 70;
                run_window(d);
                n_chk++; if (bus.code !== 9'(m_code) || bus.sat !== m_sat || bus.locked !== (m_lock == 3)) begin n_fail++; $display("FAIL rand r%0d w%0d: got %0d/%b/%b want %0d/%b/%b", r, w, bus.code, bus.sat, bus.locked, m_code, m_sat, m_lock == 3); end
                n_chk++; if (bus.delay_con_lsb !== 5'(m_code % 32) || bus.delay_con_msb !== 8'((1 << (m_code / 32)) - 1)) begin n_fail++; $display("FAIL rand_dec r%0d w%0d: got %0d/%h code %0d", r, w, bus.delay_con_lsb, bus.delay_con_msb, m_code); end
            end
            disable_cal();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cal_en = 1'b0;
        bus.target = 16'd1000;
        bus.osc_cnt = 16'd0;
        test_reset();
        test_coarse();
        test_async_reset();
        test_lock();
        test_saturation();
        test_wrap();
        test_cal_en_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
